// File: rtl/core_pkg.sv
// Shared core definitions: instruction opcodes, field positions, front-end state
// encoding and source register-file selection for the fetch/decode stage.
package core_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OFF_W = 16;
  localparam int unsigned NREG  = 32;

  // Instruction field positions
  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS_MSB  = 20;
  localparam int unsigned RS_LSB  = 16;
  localparam int unsigned RT_MSB  = 15;
  localparam int unsigned RT_LSB  = 11;
  localparam int unsigned OFF_MSB = 15;
  localparam int unsigned OFF_LSB = 0;

  // Opcodes shared with the execute stage
  localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OP_W-1:0] OP_AND  = 6'd2;
  localparam logic [OP_W-1:0] OP_OR   = 6'd3;
  localparam logic [OP_W-1:0] OP_SLL  = 6'd4;
  localparam logic [OP_W-1:0] OP_SRL  = 6'd5;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd6;
  localparam logic [OP_W-1:0] OP_SLT  = 6'd7;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'd8;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd9;
  localparam logic [OP_W-1:0] OP_J    = 6'd10;
  localparam logic [OP_W-1:0] OP_JAL  = 6'd11;
  localparam logic [OP_W-1:0] OP_JALR = 6'd12;
  localparam logic [OP_W-1:0] OP_LW   = 6'd13;
  localparam logic [OP_W-1:0] OP_SW   = 6'd14;
  localparam logic [OP_W-1:0] OP_FLW  = 6'd15;
  localparam logic [OP_W-1:0] OP_FSW  = 6'd16;
  localparam logic [OP_W-1:0] OP_FADD = 6'd17;
  localparam logic [OP_W-1:0] OP_FSUB = 6'd18;
  localparam logic [OP_W-1:0] OP_FMUL = 6'd19;
  localparam logic [OP_W-1:0] OP_FDIV = 6'd20;
  localparam logic [OP_W-1:0] OP_FEQ  = 6'd21;
  localparam logic [OP_W-1:0] OP_FLT  = 6'd22;
  localparam logic [OP_W-1:0] OP_FBEQ = 6'd23;
  localparam logic [OP_W-1:0] OP_FBNE = 6'd24;
  localparam logic [OP_W-1:0] OP_FTOI = 6'd25;
  localparam logic [OP_W-1:0] OP_ITOF = 6'd26;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    REPLAY = 2'd1,
    RUN    = 2'd2
  } fd_state_e;

  // Write-back request into one register file
  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] addr;
    logic [XLEN-1:0]  data;
  } wb_t;

  // Float arithmetic, compares, float branches and FTOI read source 1 from the float file
  function automatic logic src1_fmode(input logic [OP_W-1:0] op);
    logic f;
    f = 1'b0;
    case (op)
      OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV,
      OP_FEQ, OP_FLT, OP_FBEQ, OP_FBNE,
      OP_FTOI: f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // Only two-operand float ops read source 2 from the float file; memory data stays int
  function automatic logic src2_fmode(input logic [OP_W-1:0] op);
    logic f;
    f = 1'b0;
    case (op)
      OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV,
      OP_FEQ, OP_FLT, OP_FBEQ, OP_FBNE: f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fetch_decode_regfile_2r1w.sv
// 32x32 register file with two combinational read ports, one write port and
// write-through bypass; ZERO_R0 makes entry 0 a hard zero.
module regfile_2r1w
  import core_pkg::*;
#(
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  wb_t              wb,
  input  logic [REG_W-1:0] raddr1,
  input  logic [REG_W-1:0] raddr2,
  output logic [XLEN-1:0]  rdata1,
  output logic [XLEN-1:0]  rdata2
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_ok_c;

  // Writes to a hard-zero r0 are dropped, which also keeps them out of the bypass
  assign wr_ok_c = wb.we && !(ZERO_R0 && (wb.addr == '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok_c) begin
      regs[wb.addr] <= wb.data;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    if (wr_ok_c && (wb.addr == raddr1)) rdata1 = wb.data;
    if (wr_ok_c && (wb.addr == raddr2)) rdata2 = wb.data;
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: PC and replay FSM, instruction field split, int/float
// operand read. Optional issue counter enabled by FETCH_DECODE_COUNT_EN.
module fetch_decode
  import core_pkg::*;
#(
  parameter int unsigned IMEM_AW = 14
) (
  input  logic                clk,
  input  logic                rstn,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                enable,
  output logic [OP_W-1:0]     opecode,
  output logic [REG_W-1:0]    rd_no,
  output logic [REG_W-1:0]    rs_no,
  output logic [REG_W-1:0]    rt_no,
  output logic [OFF_W-1:0]    offset,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     rs,
  output logic [XLEN-1:0]     rt,
  output logic                fmode1,
  output logic                fmode2,
  input  logic                stop,
  input  logic                pcenable,
  input  logic [XLEN-1:0]     next_pc,
  input  logic                wenable,
  input  logic                wfmode,
  input  logic [REG_W-1:0]    wreg,
  input  logic [XLEN-1:0]     wdata,
  output logic [XLEN-1:0]     inst_count
);

  fd_state_e       state, state_next;
  logic [XLEN-1:0] pc_next;
  logic            redirect_c;
  logic            advance_c;

  // State, PC and enable register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= FETCH;
      pc     <= '0;
      enable <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      enable <= (state_next != FETCH);
    end
  end

  // Next state / next PC; a taken redirect overrides stop and forces a replay slot
  always_comb begin
    state_next = state;
    pc_next    = pc;
    redirect_c = 1'b0;
    advance_c  = 1'b0;
    case (state)
      FETCH:  state_next = REPLAY;
      REPLAY: state_next = RUN;
      RUN: begin
        state_next = RUN;
        if (!stop) begin
          advance_c = 1'b1;
          pc_next   = pc + 32'd4;
        end
      end
      default: state_next = FETCH;
    endcase
    if ((state != FETCH) && pcenable && (next_pc != pc)) begin
      redirect_c = 1'b1;
      advance_c  = 1'b0;
      state_next = REPLAY;
      pc_next    = next_pc;
    end
  end

  // Synchronous memory is addressed with the PC of next cycle's presented word
  assign imem_addr = pc_next[IMEM_AW+1:2];

  assign opecode = imem_rdata[OP_MSB:OP_LSB];
  assign rd_no   = imem_rdata[RD_MSB:RD_LSB];
  assign rs_no   = imem_rdata[RS_MSB:RS_LSB];
  assign rt_no   = imem_rdata[RT_MSB:RT_LSB];
  assign offset  = imem_rdata[OFF_MSB:OFF_LSB];

  assign fmode1 = src1_fmode(opecode);
  assign fmode2 = src2_fmode(opecode);

  wb_t             int_wb, flt_wb;
  logic [XLEN-1:0] int_rs, int_rt, flt_rs, flt_rt;

  assign int_wb = '{we: wenable && !wfmode, addr: wreg, data: wdata};
  assign flt_wb = '{we: wenable &&  wfmode, addr: wreg, data: wdata};

  regfile_2r1w #(.ZERO_R0(1'b1)) u_int_rf (
    .clk    (clk),
    .rstn   (rstn),
    .wb     (int_wb),
    .raddr1 (rs_no),
    .raddr2 (rt_no),
    .rdata1 (int_rs),
    .rdata2 (int_rt)
  );

  regfile_2r1w #(.ZERO_R0(1'b0)) u_flt_rf (
    .clk    (clk),
    .rstn   (rstn),
    .wb     (flt_wb),
    .raddr1 (rs_no),
    .raddr2 (rt_no),
    .rdata1 (flt_rs),
    .rdata2 (flt_rt)
  );

  assign rs = fmode1 ? flt_rs : int_rs;
  assign rt = fmode2 ? flt_rt : int_rt;

`ifdef FETCH_DECODE_COUNT_EN
  // Counts instructions actually issued to execute; wraps naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_count <= '0;
    end else if (advance_c) begin
      inst_count <= inst_count + 32'd1;
    end
  end
`else
  assign inst_count = '0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode with a synchronous instruction memory model.
module tb_fetch_decode;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        enable;
  logic [5:0]  opecode;
  logic [4:0]  rd_no, rs_no, rt_no;
  logic [15:0] offset;
  logic [31:0] pc, rs, rt;
  logic        fmode1, fmode2;
  logic        stop, pcenable;
  logic [31:0] next_pc;
  logic        wenable, wfmode;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [31:0] inst_count;

  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;

`ifdef FETCH_DECODE_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  fetch_decode dut (
    .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .enable(enable), .opecode(opecode), .rd_no(rd_no), .rs_no(rs_no), .rt_no(rt_no),
    .offset(offset), .pc(pc), .rs(rs), .rt(rt), .fmode1(fmode1), .fmode2(fmode2),
    .stop(stop), .pcenable(pcenable), .next_pc(next_pc), .wenable(wenable),
    .wfmode(wfmode), .wreg(wreg), .wdata(wdata), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] a,
                                      input logic [4:0] b, input logic [15:0] c);
    return {op, a, b, c};
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  task test_reset;
    #1;
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL rst_enable got %h exp 0", enable); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc); end
    checks++; if (inst_count !== 32'h0) begin errors++; $display("FAIL rst_count got %h exp 0", inst_count); end
    checks++; if (imem_addr !== 14'h0) begin errors++; $display("FAIL rst_imem_addr got %h exp 0", imem_addr); end
    rstn = 1'b1;
    #1;
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL fetch_enable got %h exp 0", enable); end
    @(negedge clk); #1;
    checks++; if (enable !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL replay_slot got en=%h pc=%h exp en=1 pc=0", enable, pc); end
    checks++; if (opecode !== OP_ADDI || rd_no !== 5'd1 || rs_no !== 5'd0 || offset !== 16'd5) begin
      errors++; $display("FAIL replay_fields got op=%h rd=%h rs=%h off=%h exp 06 01 00 0005", opecode, rd_no, rs_no, offset); end
    @(negedge clk); #1;
    checks++; if (enable !== 1'b1 || pc !== 32'h0 || opecode !== OP_ADDI) begin
      errors++; $display("FAIL run0 got en=%h pc=%h op=%h exp en=1 pc=0 op=06", enable, pc, opecode); end
    @(negedge clk); #1;
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL run4_pc got %h exp 4", pc); end
  endtask

  task test_stop;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stop_start_pc got %h exp 10", pc); end
    checks++; if (inst_count !== exp_cnt(4)) begin errors++; $display("FAIL stop_count_before got %h exp %h", inst_count, exp_cnt(4)); end
    for (int k = 0; k < 4; k++) begin
      stop = (k < 3);
      #1;
      checks++; if (pc !== 32'h10 || rd_no !== 5'd7 || rs_no !== 5'd1 || rs !== 32'h0 || rt !== 32'h0) begin
        errors++; $display("FAIL stop_hold%0d got pc=%h rd=%h rs_no=%h rs=%h rt=%h exp 10 07 01 0 0", k, pc, rd_no, rs_no, rs, rt); end
      @(negedge clk);
    end
    stop = 1'b0;
    #1;
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL stop_release_pc got %h exp 14", pc); end
    checks++; if (inst_count !== exp_cnt(5)) begin errors++; $display("FAIL stop_count_after got %h exp %h", inst_count, exp_cnt(5)); end
  endtask

  task test_redirect;
    repeat (4) @(negedge clk);
    pcenable = 1'b1; next_pc = 32'h40;
    #1;
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL redir_src_pc got %h exp 24", pc); end
    checks++; if (imem_addr !== 14'h10) begin errors++; $display("FAIL redir_imem_addr got %h exp 10", imem_addr); end
    @(negedge clk); pcenable = 1'b0; #1;
    checks++; if (pc !== 32'h40 || enable !== 1'b1) begin errors++; $display("FAIL redir_replay got pc=%h en=%h exp 40 1", pc, enable); end
    @(negedge clk); #1;
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL redir_run got %h exp 40", pc); end
    @(negedge clk); #1;
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL redir_next got %h exp 44", pc); end
    checks++; if (inst_count !== exp_cnt(10)) begin errors++; $display("FAIL redir_count got %h exp %h", inst_count, exp_cnt(10)); end
    pcenable = 1'b1; next_pc = 32'h24;
    @(negedge clk); pcenable = 1'b0;
    @(negedge clk); #1;
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL redir_back got %h exp 24", pc); end
    pcenable = 1'b1; next_pc = 32'h24;
    #1;
    checks++; if (imem_addr !== 14'h0A) begin errors++; $display("FAIL nottaken_imem_addr got %h exp 0a", imem_addr); end
    @(negedge clk); pcenable = 1'b0; #1;
    checks++; if (pc !== 32'h28 || enable !== 1'b1) begin errors++; $display("FAIL nottaken_pc got pc=%h en=%h exp 28 1", pc, enable); end
    checks++; if (inst_count !== exp_cnt(11)) begin errors++; $display("FAIL nottaken_count got %h exp %h", inst_count, exp_cnt(11)); end
  endtask

  task test_bypass;
    stop = 1'b1; wenable = 1'b1; wfmode = 1'b0; wreg = 5'd3; wdata = 32'hDEADBEEF;
    #1;
    checks++; if (rs !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs got %h exp deadbeef", rs); end
    @(negedge clk); wenable = 1'b0; #1;
    checks++; if (rs !== 32'hDEADBEEF || pc !== 32'h28) begin errors++; $display("FAIL stored_rs got rs=%h pc=%h exp deadbeef 28", rs, pc); end
    wenable = 1'b1; wfmode = 1'b1; wreg = 5'd3; wdata = 32'h12345678;
    #1;
    checks++; if (rs !== 32'hDEADBEEF) begin errors++; $display("FAIL float_wr_isolation got %h exp deadbeef", rs); end
    @(negedge clk);
    wenable = 1'b1; wfmode = 1'b0; wreg = 5'd0; wdata = 32'h7;
    #1;
    checks++; if (rt !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h exp 0", rt); end
    @(negedge clk); wenable = 1'b0; #1;
    checks++; if (rt !== 32'h0) begin errors++; $display("FAIL r0_stored got %h exp 0", rt); end
    stop = 1'b0;
  endtask

  task test_fmode;
    @(negedge clk);
    stop = 1'b1; wenable = 1'b1; wfmode = 1'b1; wreg = 5'd0; wdata = 32'h3F800000;
    #1;
    checks++; if (pc !== 32'h2C || fmode1 !== 1'b1 || fmode2 !== 1'b1) begin
      errors++; $display("FAIL fadd_decode got pc=%h f1=%h f2=%h exp 2c 1 1", pc, fmode1, fmode2); end
    checks++; if (rs !== 32'h3F800000 || rt !== 32'h12345678) begin
      errors++; $display("FAIL f0_bypass got rs=%h rt=%h exp 3f800000 12345678", rs, rt); end
    @(negedge clk); wenable = 1'b0; stop = 1'b0; #1;
    checks++; if (rs !== 32'h3F800000 || pc !== 32'h2C) begin errors++; $display("FAIL f0_stored got rs=%h pc=%h exp 3f800000 2c", rs, pc); end
    @(negedge clk); #1;
    checks++; if (opecode !== OP_FTOI || fmode1 !== 1'b1 || rs !== 32'h3F800000) begin
      errors++; $display("FAIL ftoi got op=%h f1=%h rs=%h exp 19 1 3f800000", opecode, fmode1, rs); end
    @(negedge clk); #1;
    checks++; if (opecode !== OP_ITOF || fmode1 !== 1'b0 || rs !== 32'hDEADBEEF) begin
      errors++; $display("FAIL itof got op=%h f1=%h rs=%h exp 1a 0 deadbeef", opecode, fmode1, rs); end
    @(negedge clk); #1;
    checks++; if (fmode1 !== 1'b0 || fmode2 !== 1'b0 || rt !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fsw_int got f1=%h f2=%h rt=%h exp 0 0 deadbeef", fmode1, fmode2, rt); end
  endtask

  task test_reset_mid;
    @(negedge clk);
    pcenable = 1'b1; next_pc = 32'h80;
    @(negedge clk); pcenable = 1'b0; #1;
    checks++; if (pc !== 32'h80 || enable !== 1'b1) begin errors++; $display("FAIL mid_replay got pc=%h en=%h exp 80 1", pc, enable); end
    rstn = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || enable !== 1'b0 || inst_count !== 32'h0 || imem_addr !== 14'h0) begin
      errors++; $display("FAIL mid_async_rst got pc=%h en=%h cnt=%h addr=%h exp all 0", pc, enable, inst_count, imem_addr); end
    @(negedge clk);
    rstn = 1'b1; wenable = 1'b1; wfmode = 1'b0; wreg = 5'd6; wdata = 32'h0000A5A5;
    #1;
    checks++; if (enable !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL restart_fetch got en=%h pc=%h exp 0 0", enable, pc); end
    @(negedge clk); wenable = 1'b0; #1;
    checks++; if (enable !== 1'b1 || pc !== 32'h0 || opecode !== OP_ADDI) begin
      errors++; $display("FAIL restart_replay got en=%h pc=%h op=%h exp 1 0 06", enable, pc, opecode); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if (pc !== 32'h4 || rs !== 32'h0 || rt !== 32'h0000A5A5) begin
      errors++; $display("FAIL restart_regs got pc=%h rs=%h rt=%h exp 4 0 a5a5", pc, rs, rt); end
    checks++; if (inst_count !== exp_cnt(1)) begin errors++; $display("FAIL restart_count got %h exp %h", inst_count, exp_cnt(1)); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = enc(OP_ADDI, 5'd1, 5'd0, 16'd5);
    mem[1]  = enc(OP_ADD,  5'd1, 5'd3, {5'd6, 11'd0});
    mem[4]  = enc(OP_SUB,  5'd7, 5'd1, {5'd2, 11'd0});
    mem[10] = enc(OP_ADD,  5'd5, 5'd3, {5'd0, 11'd0});
    mem[11] = enc(OP_FADD, 5'd1, 5'd0, {5'd3, 11'd0});
    mem[12] = enc(OP_FTOI, 5'd2, 5'd0, 16'd0);
    mem[13] = enc(OP_ITOF, 5'd4, 5'd3, 16'd0);
    mem[14] = enc(OP_FSW,  5'd0, 5'd3, {5'd3, 11'd0});
    rstn = 1'b0; stop = 1'b0; pcenable = 1'b0; next_pc = 32'h0;
    wenable = 1'b0; wfmode = 1'b0; wreg = 5'd0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    test_reset;
    test_stop;
    test_redirect;
    test_bypass;
    test_fmode;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
